load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the internalRam byte-addressed request/valid port.
//  - Accepts one load/store from the execute stage, range-checks it and issues
//    one enable pulse with the matching oplen.
//  - Waits for valid, then sign/zero-extends load data and returns one response.
//  - One transaction in flight. Sits between the core pipeline and RAM.
// PARAMETERS
//  MEM_BYTES    400  RAM size in bytes; accesses beyond it are rejected
//  TIMEOUT_CYC  16   WAIT cycles without mem_valid before an error response
// PORTS
//  clk         in   1   system clock
//  rst         in   1   async reset, active-high
//  req_valid   in   1   core request strobe
//  req_ready   out  1   high only in IDLE
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32 funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
//  req_addr    in   25  byte address
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   one-cycle response pulse
//  resp_err    out  1   qualifies resp_valid: illegal/range/misalign/timeout
//  resp_data   out  32  extended load data; 0 for stores and errors
//  mem_enable  out  1   one-cycle request pulse to RAM
//  mem_we      out  1   RAM write enable
//  mem_oplen   out  2   bytes-1: 00=1, 01=2, 11=4 (10 never issued)
//  mem_addr    out  25  RAM byte address
//  mem_data    out  32  RAM write data
//  mem_result  in   32  RAM read data, zero-extended by RAM
//  mem_valid   in   1   RAM completion pulse, one cycle after sampled enable
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0 except req_ready=1;
//    timeout counter=0.
//  - A RAM completion for an aborted transaction that arrives after reset is ignored.
//  - FSM states: IDLE, ISSUE, WAIT.
//  - IDLE: handshake req_valid&&req_ready at edge N. All req_* fields are
//    captured on that edge.
//  - IDLE, legal request: go to ISSUE. mem_enable=1 for exactly cycle N+1,
//    with mem_* fields stable.
//  - IDLE, error request: stay in IDLE. resp_valid=1, resp_err=1 in cycle N+1;
//    no mem_enable.
//  - Error requests are: funct3 not in {000,001,010,100,101} for loads, or not
//    in {000,001,010} for stores; or req_addr+nbytes > MEM_BYTES, with the
//    sum computed at 26 bits so it cannot wrap.
//  - ISSUE -> WAIT unconditionally; the timeout counter is cleared.
//  - WAIT, mem_valid=1: go to IDLE with resp_valid=1 in the next cycle
//    (N+3 in the nominal case).
//  - Nominal latency is 3 cycles from accept to response. req_ready is high
//    in the response cycle, so back-to-back requests are allowed.
//  - WAIT, no mem_valid: counter increments. When it reaches TIMEOUT_CYC,
//    go to IDLE with resp_err=1.
//  - mem_valid seen in IDLE or ISSUE is ignored.
//  - Load extension from mem_result:
//    LB = sign-extend [7:0]; LH = sign-extend [15:0]; LW = [31:0];
//    LBU/LHU = zero-extend.
//  - Stores: mem_data = req_wdata unmodified; RAM uses only the low oplen+1 bytes.
//  - resp_valid and resp_err are single-cycle pulses. resp_data holds its
//    value until the next response.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - halfword with addr[0]!=0, or word with addr[1:0]!=0, is an error request;
//   - it gets the one-cycle error response and no memory access.
//  MISALIGN_TRAP_EN undefined:
//   - misaligned accesses are issued as-is; RAM is byte-addressable;
//   - only the range check applies.
// TESTING
//  1 LW @0x00 after reset -> mem_enable in N+1 with oplen=11.
//    Response in N+3: resp_data=32'h00100093, err=0.
//  2 SB @0x40 wdata=32'h123456F0, then LB @0x40 -> store response data=0.
//    Load resp_data=32'hFFFFFFF0; LBU on the same address gives 32'h000000F0.
//  3 LW @0x18E (398+4>400) or funct3=011 -> err response in N+1.
//    No mem_enable is ever asserted.
//  4 LH @0x21 -> with MISALIGN_TRAP_EN: err in N+1, no access.
//    Without it: a normal 2-byte access completes in N+3.
//  5 Hold mem_valid low -> resp_err=1 after TIMEOUT_CYC WAIT cycles, then
//    req_ready=1. A late mem_valid is ignored and produces no resp_valid.
//  6 Assert rst during WAIT -> outputs 0 and req_ready=1 immediately
//    (async). A following mem_valid pulse produces no response.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Core-side initiator for the internal RAM request/valid port.
//                Accepts one load/store, range/legality checks it, issues a
//                single enable pulse, waits for completion (with timeout) and
//                returns one extended response.
//                Optional build macro: MISALIGN_TRAP_EN (misaligned halfword /
//                word accesses become error responses instead of being issued).
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_BYTES   = 400,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [24:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_data_o,
    output logic        mem_enable_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_oplen_o,
    output logic [24:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_result_i,
    input  logic        mem_valid_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int                CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [25:0]       C_MEM_BYTES = 26'(MEM_BYTES);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       oplen_q;
    logic [24:0]      addr_q;
    logic [31:0]      wdata_q;

    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      resp_data_q, resp_data_d;

    logic             w_accept;
    logic [1:0]       w_oplen;
    logic [25:0]      w_end;
    logic             w_funct_ok;
    logic             w_range_ok;
    logic             w_misalign;
    logic             w_req_err;
    logic             w_timeout;
    logic [31:0]      w_load_ext;

    // Request decode: size, legality and 26-bit (non-wrapping) range check
    always_comb begin
        w_accept = req_valid_i && req_ready_o;
        case (req_funct3_i[1:0])
            2'b00:   w_oplen = 2'b00;
            2'b01:   w_oplen = 2'b01;
            default: w_oplen = 2'b11;
        endcase
        if (req_we_i)
            w_funct_ok = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                         (req_funct3_i == 3'b010);
        else
            w_funct_ok = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                         (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                         (req_funct3_i == 3'b101);
        w_end      = {1'b0, req_addr_i} + {24'd0, w_oplen} + 26'd1;
        w_range_ok = (w_end <= C_MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
        w_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_req_err  = !w_funct_ok || !w_range_ok || w_misalign;
        w_timeout  = (state_q == ST_WAIT) && !mem_valid_i && (cnt_q == C_CNT_LAST);
    end

    // Load data extension selected by the captured funct3
    always_comb begin
        case (funct3_q)
            3'b000:  w_load_ext = {{24{mem_result_i[7]}},  mem_result_i[7:0]};
            3'b001:  w_load_ext = {{16{mem_result_i[15]}}, mem_result_i[15:0]};
            3'b100:  w_load_ext = {24'd0, mem_result_i[7:0]};
            3'b101:  w_load_ext = {16'd0, mem_result_i[15:0]};
            default: w_load_ext = mem_result_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; illegal requests never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept && !w_req_err) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem_valid_i || w_timeout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, enable exactly for the ISSUE cycle
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        mem_enable_o = (state_q == ST_ISSUE);
    end

    // Response and timeout-counter next values
    always_comb begin
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept && w_req_err) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = 32'd0;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                if (mem_valid_i) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = we_q ? 32'd0 : w_load_ext;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_timeout) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Request capture (legal requests only) and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            oplen_q      <= 2'd0;
            addr_q       <= 25'd0;
            wdata_q      <= 32'd0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            if (w_accept && !w_req_err) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                oplen_q  <= w_oplen;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_oplen_o  = oplen_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_data_o  = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a byte RAM
//                responder, a vector table, hand sequences and random traffic
//                checked against a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int C_MEM = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [24:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        mem_enable, mem_we;
    logic [1:0]  mem_oplen;
    logic [24:0] mem_addr;
    logic [31:0] mem_data, mem_result;
    logic        mem_valid;

    load_store_unit #(.MEM_BYTES(C_MEM), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_data_o(resp_data),
        .mem_enable_o(mem_enable), .mem_we_o(mem_we), .mem_oplen_o(mem_oplen),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_result_i(mem_result),
        .mem_valid_i(mem_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram    [0:C_MEM-1];
    logic [7:0] shadow [0:C_MEM-1];

    int          ram_dly    = 1;   // 0 = never answer
    bit          ram_inject = 0;
    int          pend       = 0;
    int          en_count   = 0;
    logic        cap_we;
    logic [1:0]  cap_oplen;
    logic [24:0] cap_addr;
    logic [31:0] cap_data;
    logic [31:0] ram_rdata;

    // RAM responder: samples enable, answers after ram_dly cycles
    initial begin
        mem_valid  = 1'b0;
        mem_result = 32'd0;
        ram_rdata  = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (ram_inject) begin
                mem_valid  = 1'b1;
                ram_inject = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_valid  = 1'b1;
                    mem_result = ram_rdata;
                end
            end
            if (mem_enable) begin
                en_count++;
                cap_we    = mem_we;
                cap_oplen = mem_oplen;
                cap_addr  = mem_addr;
                cap_data  = mem_data;
                ram_rdata = 32'd0;
                for (int i = 0; i <= int'(mem_oplen); i++) begin
                    if (int'(mem_addr) + i < C_MEM) begin
                        if (mem_we) ram[int'(mem_addr) + i] = mem_data[8*i +: 8];
                        else        ram_rdata[8*i +: 8] = ram[int'(mem_addr) + i];
                    end
                end
                pend = ram_dly;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [24:0] a);
        int  nb;
        bit  ok;
        nb = size_of(f3);
        ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (int'(a) + nb > C_MEM) ok = 0;
`ifdef MISALIGN_TRAP_EN
        if (int'(a) % nb != 0) ok = 0;
`endif
        return !ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [24:0] a);
        longint v;
        int     nb;
        nb = size_of(f3);
        v  = 0;
        for (int i = 0; i < nb; i++) v += longint'(shadow[int'(a) + i]) << (8 * i);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 << (8 * nb - 1)))
            v -= (64'sd1 << (8 * nb));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [24:0] a, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) shadow[int'(a) + i] = wd[8*i +: 8];
    endtask

    // Drive one request and check the whole transaction
    task automatic run_chk(input string nm, input logic we, input logic [2:0] f3,
                           input logic [24:0] a, input logic [31:0] wd, input int dly,
                           input logic exp_err, input logic [31:0] exp_data,
                           input int exp_lat, input bit exp_access, input logic [1:0] exp_oplen);
        bit          got;
        int          lat;
        logic        e;
        logic [31:0] d;
        chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
        ram_dly    = dly;
        en_count   = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_wdata  = 32'hDEADBEEF;
        got = 0; lat = 0; e = 1'b0; d = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid) begin
                got = 1; lat = c; e = resp_err; d = resp_data;
                break;
            end
            step();
        end
        chk({nm, " resp seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
            chk({nm, " err"}, {31'd0, e}, {31'd0, exp_err});
            chk({nm, " data"}, d, exp_data);
            step();
            chk({nm, " pulse"}, {30'd0, resp_valid, resp_err}, 32'd0);
            chk({nm, " hold"}, resp_data, exp_data);
        end
        chk({nm, " enables"}, 32'(en_count), exp_access ? 32'd1 : 32'd0);
        if (exp_access && en_count == 1) begin
            chk({nm, " oplen"}, {30'd0, cap_oplen}, {30'd0, exp_oplen});
            chk({nm, " addr"}, {7'd0, cap_addr}, {7'd0, a});
            chk({nm, " we"}, {31'd0, cap_we}, {31'd0, we});
            if (we) chk({nm, " wdata"}, cap_data, wd);
        end
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [24:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] data;
        logic [1:0]  oplen;
    } vec_t;

    vec_t vecs[$];
    bit   any_resp;

    initial begin
        for (int i = 0; i < C_MEM; i++) ram[i] = 8'(i) ^ 8'hA5;
        ram[0] = 8'h93; ram[1] = 8'h00; ram[2] = 8'h10; ram[3] = 8'h00;
        for (int i = 0; i < C_MEM; i++) shadow[i] = ram[i];

        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rst = 1'b1;
        step();
        chk("reset outputs", {resp_valid, resp_err, mem_enable, mem_we, mem_oplen},
            32'd0);
        chk("reset ready", {31'd0, req_ready}, 32'd1);
        chk("reset data", resp_data | mem_data | {7'd0, mem_addr}, 32'd0);
        @(negedge clk); rst = 1'b0;
        step();

        vecs.push_back('{"LW 0",        0, 3'b010, 25'h000, 32'h0,        0, 32'h00100093, 2'b11});
        vecs.push_back('{"SB 40",       1, 3'b000, 25'h040, 32'h123456F0, 0, 32'h0,        2'b00});
        vecs.push_back('{"LB 40",       0, 3'b000, 25'h040, 32'h0,        0, 32'hFFFFFFF0, 2'b00});
        vecs.push_back('{"LBU 40",      0, 3'b100, 25'h040, 32'h0,        0, 32'h000000F0, 2'b00});
        vecs.push_back('{"LW 18E",      0, 3'b010, 25'h18E, 32'h0,        1, 32'h0,        2'b11});
        vecs.push_back('{"LD f3=011",   0, 3'b011, 25'h000, 32'h0,        1, 32'h0,        2'b11});
        vecs.push_back('{"ST f3=100",   1, 3'b100, 25'h010, 32'h0,        1, 32'h0,        2'b00});
        vecs.push_back('{"LHU 22",      0, 3'b101, 25'h022, 32'h0,        0, 32'h00008687, 2'b01});
        vecs.push_back('{"LW 18C edge", 0, 3'b010, 25'h18C, 32'h0,        0, 32'h2A2B2829, 2'b11});
        vecs.push_back('{"LB 18F edge", 0, 3'b000, 25'h18F, 32'h0,        0, 32'h0000002A, 2'b00});
        vecs.push_back('{"LB 190",      0, 3'b000, 25'h190, 32'h0,        1, 32'h0,        2'b00});
        vecs.push_back('{"LW huge",     0, 3'b010, 25'h1FFFFFF, 32'h0,    1, 32'h0,        2'b11});
`ifdef MISALIGN_TRAP_EN
        vecs.push_back('{"LH 21",       0, 3'b001, 25'h021, 32'h0,        1, 32'h0,        2'b01});
`else
        vecs.push_back('{"LH 21",       0, 3'b001, 25'h021, 32'h0,        0, 32'hFFFF8784, 2'b01});
`endif

        foreach (vecs[i]) begin
            run_chk(vecs[i].nm, vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, 1,
                    vecs[i].err, vecs[i].data, vecs[i].err ? 1 : 3, !vecs[i].err,
                    vecs[i].oplen);
            if (vecs[i].we && !vecs[i].err) model_store(vecs[i].f3, vecs[i].a, vecs[i].wd);
        end

        // Timeout: RAM never answers, then a late completion is ignored
        run_chk("timeout", 0, 3'b010, 25'h004, 32'h0, 0, 1, 32'h0, 18, 1, 2'b11);
        chk("timeout ready", {31'd0, req_ready}, 32'd1);
        ram_inject = 1;
        any_resp = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid) any_resp = 1;
        end
        chk("late valid ignored", {31'd0, any_resp}, 32'd0);

        // Asynchronous reset while waiting
        ram_dly   = 0;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 25'h008;
        step();
        req_valid = 0;
        chk("rst-seq enable", {31'd0, mem_enable}, 32'd1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("async rst ready", {31'd0, req_ready}, 32'd1);
        chk("async rst outputs", {resp_valid, resp_err, mem_enable, mem_we, mem_oplen}, 32'd0);
        chk("async rst addr", {7'd0, mem_addr}, 32'd0);
        @(negedge clk); rst = 1'b0;
        ram_inject = 1;
        any_resp = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid) any_resp = 1;
        end
        chk("post-rst valid ignored", {31'd0, any_resp}, 32'd0);

        // Random traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [24:0] a;
            logic [31:0] wd;
            logic        e;
            logic [31:0] ed;
            int          dly;
            we  = 1'($urandom_range(0, 1));
            f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 2) == 0) f3 = f3 | 3'b100;
            case ($urandom_range(0, 9))
                0:       a = 25'($urandom);
                1, 2:    a = 25'($urandom_range(388, 402));
                default: a = 25'($urandom_range(0, 399));
            endcase
            wd  = $urandom;
            dly = $urandom_range(1, 4);
            e   = model_err(we, f3, a);
            ed  = (e || we) ? 32'd0 : model_load(f3, a);
            run_chk($sformatf("rnd%0d", t), we, f3, a, wd, dly, e, ed, e ? 1 : dly + 2, !e,
                    (size_of(f3) == 1) ? 2'b00 : (size_of(f3) == 2) ? 2'b01 : 2'b11);
            if (we && !e) model_store(f3, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
